// File: rtl/if_fetch_queue_if.sv
// Fetch-queue bus bundle: redirect input, instruction RAM request/response, and decode handshake.
// master = fetch unit side, slave = RAM/decode/branch-unit side.
interface if_fetch_queue_if;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [63:0] id_pc;
  logic [31:0] id_inst;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
    output imem_req_valid, imem_req_addr, id_valid, id_pc, id_inst
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
    input  imem_req_valid, imem_req_addr, id_valid, id_pc, id_inst
  );
endinterface

// File: rtl/if_fetch_queue.sv
// In-order instruction fetch queue: PC/instruction ring of DEPTH entries, redirect flush with
// late-response dropping. Optional IF_PERF_CNT_EN adds saturating fetch/flush counters.
module if_fetch_queue #(
  parameter logic [63:0] PC_START = 64'h8000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  if_fetch_queue_if.master bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [63:0]      perf_fetch_cnt,
  output logic [63:0]      perf_flush_cnt
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [63:0]   pc_mem     [DEPTH];
  logic [31:0]   inst_mem   [DEPTH];
  logic          filled_reg [DEPTH];
  logic [PW-1:0] alloc_reg, fill_reg, head_reg;
  logic [CW-1:0] used_reg, pending_reg, drop_reg;
  logic [63:0]   fetch_pc_reg;
  logic          started_reg;
  logic          id_valid_reg;
  logic [63:0]   id_pc_reg;
  logic [31:0]   id_inst_reg;

  logic          req_valid, fire, pop, rsp_drop, rsp_write;
  logic [CW:0]   occupancy;
  logic [CW-1:0] used_next, drop_flush, drop_total;
  logic [PW-1:0] head_next;
  logic          hit_fill, filled_head_next, show_next;
  logic [31:0]   inst_head_next;

  // started_reg keeps requests off for the first cycle after reset release
  assign occupancy = {1'b0, used_reg} + {1'b0, drop_reg};
  assign req_valid = rst_n & started_reg & ~bus.redirect_valid & (occupancy < DEPTH_W);
  assign fire      = req_valid & bus.imem_req_ready;
  assign pop       = rst_n & id_valid_reg & bus.id_ready;
  assign rsp_drop  = bus.imem_rsp_valid & (drop_reg != '0);
  assign rsp_write = bus.imem_rsp_valid & (drop_reg == '0) & (pending_reg != '0);

  assign drop_total = drop_reg + pending_reg;
  assign drop_flush = drop_total - CW'(bus.imem_rsp_valid && (drop_total != '0));

  // Look ahead at the head entry after this cycle's updates so id_* can be registered
  always_comb begin
    head_next        = head_reg + PW'(pop);
    used_next        = used_reg + CW'(fire) - CW'(pop);
    hit_fill         = rsp_write && (fill_reg == head_next);
    filled_head_next = filled_reg[head_next];
    if (hit_fill)
      filled_head_next = 1'b1;
    else if (fire && (alloc_reg == head_next))
      filled_head_next = 1'b0;
    inst_head_next   = hit_fill ? bus.imem_rsp_data : inst_mem[head_next];
    show_next        = (used_next != '0) && filled_head_next;
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        filled_reg[gi] <= 1'b0;
        pc_mem[gi]     <= '0;
        inst_mem[gi]   <= '0;
      end else if (!bus.redirect_valid) begin
        if (fire && (alloc_reg == PW'(gi))) begin
          filled_reg[gi] <= 1'b0;
          pc_mem[gi]     <= fetch_pc_reg;
        end else if (rsp_write && (fill_reg == PW'(gi))) begin
          filled_reg[gi] <= 1'b1;
          inst_mem[gi]   <= bus.imem_rsp_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alloc_reg    <= '0;
      fill_reg     <= '0;
      head_reg     <= '0;
      used_reg     <= '0;
      pending_reg  <= '0;
      drop_reg     <= '0;
      fetch_pc_reg <= PC_START;
      started_reg  <= 1'b0;
      id_valid_reg <= 1'b0;
      id_pc_reg    <= '0;
      id_inst_reg  <= '0;
    end else begin
      started_reg <= 1'b1;
      if (bus.redirect_valid) begin
        // Outstanding fetches become drops; a response this cycle retires one of them
        fill_reg     <= alloc_reg;
        head_reg     <= alloc_reg;
        used_reg     <= '0;
        pending_reg  <= '0;
        drop_reg     <= drop_flush;
        fetch_pc_reg <= {bus.redirect_pc[63:2], 2'b00};
        id_valid_reg <= 1'b0;
      end else begin
        if (fire) begin
          alloc_reg    <= alloc_reg + PW'(1);
          fetch_pc_reg <= fetch_pc_reg + 64'd4;
        end
        if (rsp_write)
          fill_reg <= fill_reg + PW'(1);
        head_reg     <= head_next;
        used_reg     <= used_next;
        pending_reg  <= pending_reg + CW'(fire) - CW'(rsp_write);
        drop_reg     <= drop_reg - CW'(rsp_drop);
        id_valid_reg <= show_next;
        if (show_next) begin
          id_pc_reg   <= pc_mem[head_next];
          id_inst_reg <= inst_head_next;
        end
      end
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = (rst_n & started_reg) ? fetch_pc_reg : 64'd0;
  assign bus.id_valid       = rst_n & id_valid_reg;
  assign bus.id_pc          = id_pc_reg;
  assign bus.id_inst        = id_inst_reg;

`ifdef IF_PERF_CNT_EN
  logic [63:0] fetch_cnt_reg, flush_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (rsp_write && !bus.redirect_valid && (fetch_cnt_reg != '1))
        fetch_cnt_reg <= fetch_cnt_reg + 64'd1;
      if (bus.redirect_valid && (flush_cnt_reg != '1))
        flush_cnt_reg <= flush_cnt_reg + 64'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_reg;
  assign perf_flush_cnt = flush_cnt_reg;
`endif

  rsp_owned: assert property (@(posedge clk) disable iff (!rst_n)
    bus.imem_rsp_valid |-> ((pending_reg != '0) || (drop_reg != '0)));
endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: queue-based model checked every cycle plus directed literal checks.
// Define IF_PERF_CNT_EN to also check the performance counters.
module tb_if_fetch_queue;
  localparam logic [63:0] PC_START = 64'h8000_0000;
  localparam int          DEPTH    = 4;

  typedef struct { logic [63:0] pc; logic [31:0] inst; } ent_t;
  typedef struct { logic [63:0] addr; int due; } mreq_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  if_fetch_queue_if bus();

`ifdef IF_PERF_CNT_EN
  logic [63:0] perf_fetch_cnt, perf_flush_cnt;
  if_fetch_queue #(.PC_START(PC_START), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt));
`else
  if_fetch_queue #(.PC_START(PC_START), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  logic [63:0] m_fetch_pc, m_last_pc;
  logic [31:0] m_last_inst;
  logic [63:0] m_inflight[$];
  ent_t        m_ready[$];
  int          m_drop = 0, m_dropped = 0, m_kept = 0, m_flush = 0;
  bit          m_started = 0, m_in_reset = 0, m_armed = 0;
  bit          e_rv, e_iv;
  logic [63:0] e_addr;

  always @(negedge clk) begin : cmp
    if (!rst_n) begin
      check("rst_req_valid", bus.imem_req_valid, 0);
      check("rst_req_addr", bus.imem_req_addr, 0);
      check("rst_id_valid", bus.id_valid, 0);
      if (m_in_reset) begin
        check("rst_id_pc", bus.id_pc, 0);
        check("rst_id_inst", bus.id_inst, 0);
`ifdef IF_PERF_CNT_EN
        check("rst_perf_fetch", perf_fetch_cnt, 0);
        check("rst_perf_flush", perf_flush_cnt, 0);
`endif
      end
      m_fetch_pc = PC_START; m_inflight.delete(); m_ready.delete();
      m_drop = 0; m_started = 0; m_last_pc = 0; m_last_inst = 0;
      m_kept = 0; m_flush = 0; m_in_reset = 1; m_armed = 1;
    end else if (m_armed) begin
      e_rv   = m_started && !bus.redirect_valid &&
               (m_inflight.size() + m_ready.size() + m_drop < DEPTH);
      e_addr = m_started ? m_fetch_pc : 64'd0;
      e_iv   = m_ready.size() > 0;
      if (e_iv) begin
        m_last_pc   = m_ready[0].pc;
        m_last_inst = m_ready[0].inst;
      end
      check("req_valid", bus.imem_req_valid, e_rv);
      check("req_addr", bus.imem_req_addr, e_addr);
      check("id_valid", bus.id_valid, e_iv);
      check("id_pc", bus.id_pc, m_last_pc);
      check("id_inst", bus.id_inst, m_last_inst);
`ifdef IF_PERF_CNT_EN
      check("perf_fetch", perf_fetch_cnt, m_kept);
      check("perf_flush", perf_flush_cnt, m_flush);
`endif
      if (bus.redirect_valid) begin
        if (bus.imem_rsp_valid && (m_drop + m_inflight.size() > 0))
          m_drop = m_drop + m_inflight.size() - 1;
        else
          m_drop = m_drop + m_inflight.size();
        m_inflight.delete(); m_ready.delete();
        m_fetch_pc = bus.redirect_pc & ~64'h3;
        m_flush++;
      end else begin
        if (e_iv && bus.id_ready) void'(m_ready.pop_front());
        if (bus.imem_rsp_valid) begin
          if (m_drop > 0) begin
            m_drop--; m_dropped++;
          end else if (m_inflight.size() > 0) begin
            ent_t e;
            e.pc = m_inflight.pop_front();
            e.inst = bus.imem_rsp_data;
            m_ready.push_back(e);
            m_kept++;
          end
        end
        if (e_rv && bus.imem_req_ready) begin
          m_inflight.push_back(m_fetch_pc);
          m_fetch_pc = m_fetch_pc + 64'd4;
        end
      end
      m_started = 1; m_in_reset = 0;
    end
  end

  // ---------------- instruction RAM stand-in and cycle stepping ----------------
  mreq_t       memq[$];
  int          cyc = 0, lat = 1;
  bit          rsp_en = 1;
  logic [63:0] fire_addrs[$];
  logic [63:0] popped[$];

  task automatic tick();
    bit s_fire, s_rsp;
    logic [63:0] s_addr;
    @(negedge clk);
    s_fire = bus.imem_req_valid & bus.imem_req_ready;
    s_rsp  = bus.imem_rsp_valid;
    s_addr = bus.imem_req_addr;
    if (s_fire) fire_addrs.push_back(s_addr);
    if (bus.id_valid & bus.id_ready) popped.push_back(bus.id_pc);
    @(posedge clk);
    #2;
    cyc++;
    if (!rst_n) memq.delete();
    else begin
      if (s_rsp && memq.size() > 0) void'(memq.pop_front());
      if (s_fire) begin
        mreq_t r;
        r.addr = s_addr; r.due = cyc - 1 + lat;
        memq.push_back(r);
      end
    end
    if (rsp_en && memq.size() > 0 && memq[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = inst_of(memq[0].addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'd0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    repeat (2) tick();
    fire_addrs.delete();
    popped.delete();
  endtask

  int d0;

  initial begin
    bus.redirect_valid = 1'b0; bus.redirect_pc = 64'd0;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = 32'd0;
    bus.id_ready = 1'b0;
    do_reset();

    // 1: streaming with 1-cycle RAM, decode always ready
    rst_n = 1'b1; bus.imem_req_ready = 1'b1; bus.id_ready = 1'b1; lat = 1; rsp_en = 1;
    #1;
    check("t1_first_cycle_req_valid", bus.imem_req_valid, 0);
    check("t1_first_cycle_id_valid", bus.id_valid, 0);
    repeat (12) tick();
    check("t1_fire_count", fire_addrs.size(), 11);
    check("t1_pop_count", popped.size(), 9);
    if (fire_addrs.size() > 0) check("t1_first_addr", fire_addrs[0], 64'h8000_0000);
    if (popped.size() > 2) begin
      check("t1_pop0", popped[0], 64'h8000_0000);
      check("t1_pop1", popped[1], 64'h8000_0004);
      check("t1_pop2", popped[2], 64'h8000_0008);
    end

    // 2: decode stalled fills the ring, then drains in order
    do_reset();
    rst_n = 1'b1; bus.id_ready = 1'b0;
    repeat (10) tick();
    #1;
    check("t2_fire_count", fire_addrs.size(), 4);
    check("t2_req_valid_full", bus.imem_req_valid, 0);
    check("t2_id_pc_held", bus.id_pc, 64'h8000_0000);
    bus.id_ready = 1'b1;
    repeat (4) tick();
    check("t2_pop_count", popped.size(), 4);
    if (popped.size() > 3) check("t2_pop3", popped[3], 64'h8000_000C);
    check("t2_fire_total", fire_addrs.size(), 7);

    // 3: redirect with three fetches outstanding
    do_reset();
    rst_n = 1'b1; rsp_en = 0;
    repeat (4) tick();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h8000_0100;
    #1;
    check("t3_no_req_on_redirect", bus.imem_req_valid, 0);
    d0 = m_dropped;
    tick();
    bus.redirect_valid = 1'b0; rsp_en = 1;
    fire_addrs.delete(); popped.delete();
    repeat (12) tick();
    check("t3_dropped", m_dropped - d0, 3);
    if (fire_addrs.size() > 0) check("t3_refetch_addr", fire_addrs[0], 64'h8000_0100);
    if (popped.size() > 0) check("t3_first_pop", popped[0], 64'h8000_0100);
    else check("t3_pop_seen", popped.size(), 1);

    // 4: redirect coinciding with a response, two unfilled
    do_reset();
    rst_n = 1'b1; lat = 2;
    repeat (8) tick();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h8000_0400;
    d0 = m_dropped;
    tick();
    bus.redirect_valid = 1'b0;
    check("t4_drop_cnt", m_drop, 1);
    popped.delete();
    repeat (10) tick();
    check("t4_dropped", m_dropped - d0, 1);
    if (popped.size() > 0) check("t4_first_pop", popped[0], 64'h8000_0400);
    else check("t4_pop_seen", popped.size(), 1);
`ifdef IF_PERF_CNT_EN
    check("t4_perf_flush", perf_flush_cnt, 1);
`endif

    // 5: RAM back-pressure holds the address; misaligned redirect target
    do_reset();
    rst_n = 1'b1; lat = 1; bus.imem_req_ready = 1'b0;
    repeat (6) tick();
    #1;
    check("t5_req_valid_held", bus.imem_req_valid, 1);
    check("t5_addr_held", bus.imem_req_addr, 64'h8000_0000);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h8000_0203;
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    check("t5_aligned_addr", bus.imem_req_addr, 64'h8000_0200);
    bus.imem_req_ready = 1'b1;
    fire_addrs.delete();
    repeat (3) tick();
    if (fire_addrs.size() > 0) check("t5_fire_addr", fire_addrs[0], 64'h8000_0200);
    else check("t5_fire_seen", fire_addrs.size(), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
